if_id_buf: RTL and testbench

//  Fetch-to-decode boundary stage: captures {pc, inst} pairs returned by the instruction ROM one cycle after
//  pc_reg issues an address, presents them to decode, and absorbs in-flight fetches in a small skid FIFO

---
 rtl/if_id_buf_pkg.sv | 14 +
 rtl/if_id_fifo.sv | 64 ++++++
 rtl/if_id_buf.sv | 125 ++++++++++++
 tb/tb_if_id_buf.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buf_pkg.sv
// Shared constants and helpers for the fetch/decode boundary buffer.
package if_id_buf_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;
  // Opcode presented to decode whenever the stage carries a bubble.
  localparam logic [INST_W-1:0]      NOP_INST  = '0;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/if_id_fifo.sv
// Skid FIFO holding {pc, inst} beats that arrive while decode is stalled.
module if_id_fifo
  import if_id_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_id_buf.sv
// IF/ID boundary register with skid FIFO. Optional perf counters under IF_ID_PERF_EN.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] if_pc,
  input  logic [DW-1:0] if_inst,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic          id_stall,
  input  logic          flush,
  output logic [AW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
  output logic          id_valid,
  output logic          ovf_err
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   bubble_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Handshake: if_ready is a fetch permission, not a per-beat acceptance.
  // A beat with if_valid=1 is always taken (bypassed, queued or flushed);
  // if_ready only tells pc_reg whether it may issue the next fetch, and one
  // FIFO slot is kept free for the fetch already in flight.

  logic [AW+DW-1:0] fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clr;
  logic             ovf_set;
  logic             nxt_valid;
  logic [AW-1:0]    nxt_pc;
  logic [DW-1:0]    nxt_inst;

  if_id_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({if_pc, if_inst}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign if_ready = (fifo_count < CW'(DEPTH - 1));

  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    ovf_set   = 1'b0;
    nxt_valid = id_valid;
    nxt_pc    = id_pc;
    nxt_inst  = id_inst;
    if (flush) begin
      fifo_clr  = 1'b1;
      nxt_valid = 1'b0;
      nxt_pc    = AW'(ZERO_WORD);
      nxt_inst  = DW'(NOP_INST);
    end else if (id_stall) begin
      fifo_push = if_valid;
      ovf_set   = if_valid && fifo_full;
    end else if (!fifo_empty) begin
      // Older queued work goes first; the incoming beat joins the tail.
      fifo_pop  = 1'b1;
      fifo_push = if_valid;
      nxt_valid = 1'b1;
      nxt_pc    = fifo_rdata[AW+DW-1:DW];
      nxt_inst  = fifo_rdata[DW-1:0];
    end else if (if_valid) begin
      nxt_valid = 1'b1;
      nxt_pc    = if_pc;
      nxt_inst  = if_inst;
    end else begin
      nxt_valid = 1'b0;
      nxt_pc    = AW'(ZERO_WORD);
      nxt_inst  = DW'(NOP_INST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      id_valid <= nxt_valid;
      id_pc    <= nxt_pc;
      id_inst  <= nxt_inst;
      if (ovf_set) ovf_err <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (id_stall && id_valid) stall_cnt  <= stall_cnt + 32'd1;
      if (!id_valid)            bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: vector table, reset/perf sequences, ordered stream.
module tb_if_id_buf;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_ready;
  logic        id_stall;
  logic        flush;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        ovf_err;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_cmp;
  int n_bad;
  logic [31:0] exp_q[$];

  if_id_buf #(.DEPTH(2), .AW(32), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .id_stall (id_stall),
    .flush    (flush),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .ovf_err  (ovf_err)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    if_valid = v;
    if_pc    = v ? pc : 32'h0;
    if_inst  = v ? mk_inst(pc) : 32'h0;
    id_stall = st;
    flush    = fl;
  endtask

  // advance one clock, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        st;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_ready;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic st,
                               input logic fl, input logic ev, input logic [31:0] epc,
                               input logic erdy, input logic eovf);
    vec_t r;
    r.v = v; r.pc = pc; r.st = st; r.fl = fl;
    r.e_valid = ev; r.e_pc = epc; r.e_ready = erdy; r.e_ovf = eovf;
    return r;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // inputs -> outputs seen after the following edge
    vecs.push_back(mkv(1, 32'h00, 0, 0, 1, 32'h00, 1, 0));
    vecs.push_back(mkv(1, 32'h04, 0, 0, 1, 32'h04, 1, 0));
    vecs.push_back(mkv(1, 32'h08, 0, 0, 1, 32'h08, 1, 0));
    vecs.push_back(mkv(1, 32'h0C, 1, 0, 1, 32'h08, 0, 0));
    vecs.push_back(mkv(1, 32'h10, 1, 0, 1, 32'h08, 0, 0));
    vecs.push_back(mkv(0, 32'h00, 1, 0, 1, 32'h08, 0, 0));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 1, 32'h0C, 0, 0));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 1, 32'h10, 1, 0));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 0, 32'h00, 1, 0));
    vecs.push_back(mkv(1, 32'h14, 1, 0, 0, 32'h00, 0, 0));
    vecs.push_back(mkv(1, 32'h18, 1, 0, 0, 32'h00, 0, 0));
    vecs.push_back(mkv(1, 32'h1C, 1, 1, 0, 32'h00, 1, 0));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 0, 32'h00, 1, 0));
    vecs.push_back(mkv(1, 32'h20, 0, 0, 1, 32'h20, 1, 0));
    vecs.push_back(mkv(1, 32'h30, 1, 0, 1, 32'h20, 0, 0));
    vecs.push_back(mkv(1, 32'h34, 0, 0, 1, 32'h30, 0, 0));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 1, 32'h34, 1, 0));
    vecs.push_back(mkv(1, 32'h24, 1, 0, 1, 32'h34, 0, 0));
    vecs.push_back(mkv(1, 32'h28, 1, 0, 1, 32'h34, 0, 0));
    vecs.push_back(mkv(1, 32'h2C, 1, 0, 1, 32'h34, 0, 1));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 1, 32'h24, 0, 1));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 1, 32'h28, 1, 1));
    vecs.push_back(mkv(0, 32'h00, 0, 0, 0, 32'h00, 1, 1));
    vecs.push_back(mkv(0, 32'h00, 0, 1, 0, 32'h00, 1, 1));

    // reset values while rst is held
    #12;
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_if_ready", {31'h0, if_ready}, 32'h1);
    chk("rst_ovf", {31'h0, ovf_err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].st, vecs[i].fl);
      step();
      chk($sformatf("v%0d_id_valid", i), {31'h0, id_valid}, {31'h0, vecs[i].e_valid});
      chk($sformatf("v%0d_id_pc", i), id_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_id_inst", i), id_inst,
          vecs[i].e_valid ? mk_inst(vecs[i].e_pc) : 32'h0);
      chk($sformatf("v%0d_if_ready", i), {31'h0, if_ready}, {31'h0, vecs[i].e_ready});
      chk($sformatf("v%0d_ovf", i), {31'h0, ovf_err}, {31'h0, vecs[i].e_ovf});
    end

    // ---- async reset mid-stall with one queued entry ----
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h44, 1'b1, 1'b0);
    step();
    chk("pre_rst_id_pc", id_pc, 32'h40);
    chk("pre_rst_if_ready", {31'h0, if_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("async_rst_id_pc", id_pc, 32'h0);
    chk("async_rst_id_inst", id_inst, 32'h0);
    chk("async_rst_if_ready", {31'h0, if_ready}, 32'h1);
    chk("async_rst_ovf", {31'h0, ovf_err}, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;

`ifdef IF_ID_PERF_EN
    // ---- perf counters: 1 bubble, 5 stalled valid cycles, 1 more bubble ----
    chk("perf_stall_init", stall_cnt, 32'h0);
    chk("perf_bubble_init", bubble_cnt, 32'h0);
    drive(1'b1, 32'h50, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("perf_stall_cnt", stall_cnt, 32'd5);
    chk("perf_bubble_cnt", bubble_cnt, 32'd2);
`endif

    // ---- ordered stream: pc_reg honours if_ready, decode stalls at random ----
    begin
      int       sent;
      logic     issued;
      logic     issue_next;
      logic [31:0] pc_next;
      logic [31:0] got;
      int       cyc;
      sent   = 0;
      issued = 1'b0;
      pc_next = 32'h100;
      cyc    = 0;
      while ((sent < 20 || issued || exp_q.size() != 0) && cyc < 400) begin
        drive(issued, pc_next, ($urandom_range(0, 2) == 0), 1'b0);
        if (issued) begin
          exp_q.push_back(pc_next);
          pc_next = pc_next + 32'h4;
        end
        if (id_valid && !id_stall) begin
          if (exp_q.size() == 0) begin
            chk("stream_unexpected", id_pc, 32'hFFFF_FFFF);
          end else begin
            got = exp_q.pop_front();
            chk("stream_pc", id_pc, got);
            chk("stream_inst", id_inst, mk_inst(got));
          end
        end
        issue_next = if_ready && (sent < 20);
        if (issue_next) sent++;
        step();
        issued = issue_next;
        cyc++;
      end
      chk("stream_drained", exp_q.size(), 32'h0);
      chk("stream_sent", sent, 32'd20);
      chk("stream_ovf", {31'h0, ovf_err}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
